// File: rtl/quad_arb.sv
// quad_arb: round-robin arbiter/sequencer sharing a 2-cycle sum-of-squares unit among N_REQ requesters.
// Optional build macro QUAD_ARB_PRIO0_EN gives requester 0 strict priority over the round robin.
module quad_arb #(
    parameter int N_REQ      = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int ID_W       = $clog2(N_REQ)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [N_REQ*14-1:0]   req_a,
    input  logic [N_REQ*14-1:0]   req_b,
    output logic [13:0]           q_a,
    output logic [13:0]           q_b,
    input  logic [28:0]           q_c,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [28:0]           resp_c,
    output logic [ID_W-1:0]       resp_id
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [13:0] w_a [N_REQ];
    logic [13:0] w_b [N_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign w_a[gi] = req_a[14*gi +: 14];
            assign w_b[gi] = req_b[14*gi +: 14];
        end
    endgenerate

    logic [ID_W-1:0] r_rr_ptr;
    logic [2:0]      r_tag_v;
    logic [ID_W-1:0] r_tag_id [3];
    logic [28:0]     r_mem_c  [FIFO_DEPTH];
    logic [ID_W-1:0] r_mem_id [FIFO_DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;

    logic            w_found;
    logic [ID_W-1:0] w_win;
    logic [ID_W-1:0] w_idx;
    logic [ID_W-1:0] w_rr_next;
    logic [1:0]      w_inflight;
    logic            w_credit;
    logic            w_accept;
    logic            w_push;
    logic            w_pop;

    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_idx = ID_W'((int'(r_rr_ptr) + k) % N_REQ);
            if (!w_found && req_valid[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
`ifdef QUAD_ARB_PRIO0_EN
        if (req_valid[0]) begin
            w_found = 1'b1;
            w_win   = '0;
        end
`endif
    end

    // A pop in the same cycle deliberately does not count as a free slot.
    assign w_inflight = 2'(r_tag_v[0]) + 2'(r_tag_v[1]) + 2'(r_tag_v[2]);
    assign w_credit   = (int'(w_inflight) + int'(r_count)) < FIFO_DEPTH;

    always_comb begin
        req_ready = '0;
        if (rstn && w_found && w_credit)
            req_ready[w_win] = 1'b1;
    end

    assign w_accept  = |(req_valid & req_ready);
    assign w_push    = r_tag_v[2];
    assign w_pop     = resp_valid & resp_ready;
    assign w_rr_next = (w_win == ID_W'(N_REQ-1)) ? '0 : w_win + ID_W'(1);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            q_a      <= '0;
            q_b      <= '0;
            r_tag_v  <= '0;
            r_rr_ptr <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int k = 0; k < 3; k++)
                r_tag_id[k] <= '0;
        end else begin
            q_a         <= w_accept ? w_a[w_win] : '0;
            q_b         <= w_accept ? w_b[w_win] : '0;
            r_tag_v     <= {r_tag_v[1:0], w_accept};
            r_tag_id[0] <= w_win;
            r_tag_id[1] <= r_tag_id[0];
            r_tag_id[2] <= r_tag_id[1];
            if (w_accept) begin
`ifdef QUAD_ARB_PRIO0_EN
                if (w_win != '0)
                    r_rr_ptr <= w_rr_next;
`else
                r_rr_ptr <= w_rr_next;
`endif
            end
            if (w_push)
                r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_push && !w_pop)
                r_count <= r_count + CW'(1);
            else if (!w_push && w_pop)
                r_count <= r_count - CW'(1);
            if (w_push && !w_pop)
                assert (r_count < CW'(FIFO_DEPTH));
        end
    end

    // tag2 lines up with the datapath result, so both enter the FIFO together.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_c[r_wr_ptr]  <= q_c;
            r_mem_id[r_wr_ptr] <= r_tag_id[2];
        end
    end

    assign resp_valid = (r_count != '0);
    assign resp_c     = resp_valid ? r_mem_c[r_rd_ptr]  : '0;
    assign resp_id    = resp_valid ? r_mem_id[r_rd_ptr] : '0;

endmodule

// File: tb/tb_quad_arb.sv
// tb_quad_arb: directed bench for quad_arb with a behavioural 2-cycle sum-of-squares datapath.
module tb_quad_arb;
    logic        clk = 1'b0;
    logic        rstn;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [55:0] req_a;
    logic [55:0] req_b;
    logic [13:0] q_a;
    logic [13:0] q_b;
    logic [28:0] q_c;
    logic        resp_valid;
    logic        resp_ready;
    logic [28:0] resp_c;
    logic [1:0]  resp_id;
    logic [27:0] sq_a;
    logic [27:0] sq_b;

    int checks   = 0;
    int failures = 0;
    int          grant_q[$];
    logic [28:0] rc_q[$];
    int          rid_q[$];
    logic [13:0] ta[4];
    logic [13:0] tbv[4];

    always #5 clk = ~clk;

    quad_arb #(.N_REQ(4), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .q_a(q_a), .q_b(q_b), .q_c(q_c),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_c(resp_c), .resp_id(resp_id)
    );

    always @(posedge clk) begin
        sq_a <= 28'(q_a) * 28'(q_a);
        sq_b <= 28'(q_b) * 28'(q_b);
        q_c  <= 29'(sq_a) + 29'(sq_b);
    end

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (req_valid[i] && req_ready[i]) grant_q.push_back(i);
        if (resp_valid && resp_ready) begin
            rc_q.push_back(resp_c);
            rid_q.push_back(int'(resp_id));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] sos(input logic [13:0] a, input logic [13:0] b);
        return 32'(a) * 32'(a) + 32'(b) * 32'(b);
    endfunction

    function automatic int exp_grant(input int k);
`ifdef QUAD_ARB_PRIO0_EN
        return 0 * k;
`else
        return k % 4;
`endif
    endfunction

    function automatic logic [31:0] get_g(input int k);
        if (k < grant_q.size()) return 32'(grant_q[k]);
        return 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] get_c(input int k);
        if (k < rc_q.size()) return 32'(rc_q[k]);
        return 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] get_id(input int k);
        if (k < rid_q.size()) return 32'(rid_q[k]);
        return 32'hFFFF_FFFF;
    endfunction

    task automatic set_op(input int i, input logic [13:0] a, input logic [13:0] b);
        req_a[14*i +: 14] = a;
        req_b[14*i +: 14] = b;
    endtask

    task automatic clear_q();
        grant_q.delete();
        rc_q.delete();
        rid_q.delete();
    endtask

    task automatic wait_resp(input int n, input string tag);
        for (int t = 0; t < 40 && rc_q.size() < n; t++) tick();
        chk(tag, 32'(rc_q.size()), 32'(n));
    endtask

    initial begin
        // Reset state, with requests asserted to show req_ready is held low
        rstn = 1'b0; req_valid = 4'hF; req_a = '0; req_b = '0; resp_ready = 1'b1;
        tick(); tick();
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_qa", 32'(q_a), 32'd0);
        chk("rst_qb", 32'(q_b), 32'd0);
        chk("rst_valid", 32'(resp_valid), 32'd0);
        chk("rst_c", 32'(resp_c), 32'd0);
        chk("rst_id", 32'(resp_id), 32'd0);
        req_valid = '0; rstn = 1'b1;
        tick();
        clear_q();

        // Single request from requester 2: 3*3 + 4*4
        set_op(2, 14'd3, 14'd4); req_valid = 4'b0100; #1;
        chk("t1_ready", 32'(req_ready), 32'h4);
        tick();
        req_valid = '0; #1;
        chk("t1_qa", 32'(q_a), 32'd3);
        chk("t1_qb", 32'(q_b), 32'd4);
        chk("t1_lat0", 32'(resp_valid), 32'd0);
        tick();
        chk("t1_lat1", 32'(resp_valid), 32'd0);
        tick();
        chk("t1_lat2", 32'(resp_valid), 32'd0);
        tick();
        chk("t1_valid", 32'(resp_valid), 32'd1);
        chk("t1_c", 32'(resp_c), 32'd25);
        chk("t1_id", 32'(resp_id), 32'd2);
        tick();
        chk("t1_popped", 32'(resp_valid), 32'd0);

        // Maximum operands, no truncation
        clear_q();
        set_op(1, 14'd16383, 14'd16383); req_valid = 4'b0010; #1;
        chk("t2_ready", 32'(req_ready), 32'h2);
        tick();
        req_valid = '0;
        wait_resp(1, "t2_cnt");
        chk("t2_c", get_c(0), 32'd536805378);
        chk("t2_id", get_id(0), 32'd1);

        // All four held valid from a fresh pointer
        rstn = 1'b0; tick(); rstn = 1'b1;
        clear_q();
        for (int i = 0; i < 4; i++) begin
            ta[i]  = 14'(100 * (i + 1) + 7);
            tbv[i] = 14'(50 * i + 3);
            set_op(i, ta[i], tbv[i]);
        end
        req_valid = 4'hF;
        for (int t = 0; t < 40 && grant_q.size() < 8; t++) tick();
        req_valid = '0;
        chk("t3_grants", 32'(grant_q.size()), 32'd8);
        wait_resp(8, "t3_resp");
        for (int k = 0; k < 8; k++) begin
            chk("t3_grant", get_g(k), 32'(exp_grant(k)));
            chk("t3_id", get_id(k), 32'(exp_grant(k)));
            chk("t3_c", get_c(k), sos(ta[exp_grant(k)], tbv[exp_grant(k)]));
        end

        // Backpressure: four accepts fill the FIFO, then issue stops
        clear_q();
        resp_ready = 1'b0; req_valid = 4'hF;
        for (int t = 0; t < 10; t++) tick();
        chk("t4_accepts", 32'(grant_q.size()), 32'd4);
        chk("t4_blocked", 32'(req_ready), 32'd0);
        chk("t4_full_valid", 32'(resp_valid), 32'd1);
        resp_ready = 1'b1; #1;
        chk("t4_same_cycle", 32'(req_ready), 32'd0);
        tick();
        chk("t4_resume", 32'(req_ready), 32'h1);
        req_valid = '0;
        wait_resp(4, "t4_drain");
        for (int k = 0; k < 4; k++) begin
            chk("t4_grant", get_g(k), 32'(exp_grant(k)));
            chk("t4_id", get_id(k), 32'(exp_grant(k)));
            chk("t4_c", get_c(k), sos(ta[exp_grant(k)], tbv[exp_grant(k)]));
        end
        chk("t4_grant_total", 32'(grant_q.size()), 32'd4);

        // Simultaneous push and pop with two entries queued
        clear_q();
        resp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            set_op(1, 14'(10 + k), 14'(20 + k)); req_valid = 4'b0010; #1;
            chk("t5_ready", 32'(req_ready), 32'h2);
            tick();
        end
        req_valid = '0;
        tick();
        tick();
        chk("t5_head1", 32'(resp_c), sos(14'd10, 14'd20));
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0; #1;
        chk("t5_head2", 32'(resp_c), sos(14'd11, 14'd21));
        tick();
        chk("t5_hold", 32'(resp_c), sos(14'd11, 14'd21));
        chk("t5_hold_id", 32'(resp_id), 32'd1);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0; #1;
        chk("t5_head3", 32'(resp_c), sos(14'd12, 14'd22));
        resp_ready = 1'b1;
        tick();
        chk("t5_empty", 32'(resp_valid), 32'd0);
        chk("t5_popped", 32'(rc_q.size()), 32'd3);

        // Reset with three operations in flight
        clear_q();
        for (int i = 0; i < 3; i++) set_op(i, ta[i], tbv[i]);
        req_valid = 4'b0111;
        tick(); tick(); tick();
        req_valid = 4'hF; rstn = 1'b0;
        tick();
        chk("t6_ready", 32'(req_ready), 32'd0);
        chk("t6_qa", 32'(q_a), 32'd0);
        chk("t6_qb", 32'(q_b), 32'd0);
        chk("t6_valid", 32'(resp_valid), 32'd0);
        chk("t6_c", 32'(resp_c), 32'd0);
        chk("t6_id", 32'(resp_id), 32'd0);
        rstn = 1'b1; req_valid = '0;
        for (int t = 0; t < 8; t++) tick();
        chk("t6_no_stale", 32'(rc_q.size()), 32'd0);
        chk("t6_grants", 32'(grant_q.size()), 32'd3);
        set_op(3, 14'd5, 14'd12); req_valid = 4'b1000; #1;
        chk("t6_new_ready", 32'(req_ready), 32'h8);
        tick();
        req_valid = '0;
        wait_resp(1, "t6_cnt");
        chk("t6_new_c", get_c(0), 32'd169);
        chk("t6_new_id", get_id(0), 32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
